// File: rtl/scan_pkg.sv
// Shared widths and FSM state encoding for the frame-scan sequencer
// and its delay-line helper.
package scan_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LINE = 2'd1;
  localparam state_t ST_HBLK = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/scan_delay.sv
// Fixed-depth shift register (DEPTH >= 1 cycles, no stall input); used to
// align {de,row,col} with line-buffer tap latency.
module scan_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame-scan sequencer: reads a stored image raster-order and streams it to the
// line buffer (1-cycle issue-to-stream, WIN_LAT more to window strobe); no backpressure.
module window_scan_ctrl
  import scan_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int ADDR_W      = 12,
  parameter int HBLANK      = 2,
  parameter int FLUSH_LINES = 1,
  parameter int WIN_LAT     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_data,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_de,
  output logic               pix_hs,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col
);

  localparam int ROW_W      = COORD_W + 1;
  localparam int TOTAL_ROWS = IMG_H + FLUSH_LINES;
  localparam int LAST_ADDR  = IMG_W * IMG_H - 1;
  localparam int BLK_W      = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int DLY_W      = 1 + ROW_W + COORD_W;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               de_q, img_q;
  logic [ROW_W-1:0]   srow_q;
  logic [COORD_W-1:0] scol_q;

  logic               img_row, line_end, blk_end;
  logic [ROW_W-1:0]   row_inc;

  assign img_row  = (row_q < ROW_W'(IMG_H));
  assign line_end = (col_q == COORD_W'(IMG_W - 1));
  assign blk_end  = (blk_q == BLK_W'(HBLANK - 1));
  assign row_inc  = row_q + 1'b1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    blk_d   = blk_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LINE;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      ST_LINE: begin
        // Address is contiguous across rows; it parks on the last pixel so it never wraps.
        if (img_row && (addr_q != ADDR_W'(LAST_ADDR))) addr_d = addr_q + 1'b1;
        if (line_end) begin
          col_d   = '0;
          blk_d   = '0;
          state_d = ST_HBLK;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_HBLK: begin
        if (blk_end) begin
          row_d   = row_inc;
          state_d = (row_inc < ROW_W'(TOTAL_ROWS)) ? ST_LINE : ST_DONE;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      blk_q   <= '0;
      addr_q  <= '0;
      de_q    <= 1'b0;
      img_q   <= 1'b0;
      srow_q  <= '0;
      scol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
      de_q    <= (state_q == ST_LINE);
      img_q   <= img_row;
      srow_q  <= row_q;
      scol_q  <= col_q;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mem_rd   = (state_q == ST_LINE) && img_row;
  assign mem_addr = addr_q;

  // Read data lands one cycle after issue, so the stream stage takes it directly.
  assign pix_out = (de_q && img_q) ? mem_data : '0;
  assign pix_de  = de_q;
  assign pix_hs  = de_q;

  logic [DLY_W-1:0]   win_dly;
  logic               dly_de;
  logic [ROW_W-1:0]   dly_row;
  logic [COORD_W-1:0] dly_col;

  scan_delay #(
    .DEPTH (WIN_LAT),
    .WIDTH (DLY_W)
  ) u_win_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  ({de_q, srow_q, scol_q}),
    .dout_o (win_dly)
  );

  assign dly_de  = win_dly[DLY_W-1];
  assign dly_row = win_dly[COORD_W +: ROW_W];
  assign dly_col = win_dly[COORD_W-1:0];

  // Window centre sits one row behind the row being shifted in.
  assign win_valid = dly_de && (dly_row != '0);
  assign win_row   = win_valid ? COORD_W'(dly_row - 1'b1) : '0;
  assign win_col   = win_valid ? dly_col : '0;

  a_addr_map: assert property (@(posedge clk) disable iff (reset)
    mem_rd |-> (32'(mem_addr) == 32'(row_q) * IMG_W + 32'(col_q)));

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: arithmetic frame model checked every cycle, scenario table,
// hand sequences for hs gaps and back-to-back frames, then randomized start/reset traffic.
module tb_window_scan_ctrl;

  localparam int W = 4, H = 3, HB = 2, FL = 1, WL = 2, AW = 12;
  localparam int P  = W + HB;
  localparam int FR = (H + FL) * P;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, mem_rd, pix_de, pix_hs, win_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic [7:0]  pix_out;
  logic [9:0]  win_row, win_col;

  window_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .HBLANK(HB), .FLUSH_LINES(FL), .WIN_LAT(WL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pix_out(pix_out), .pix_de(pix_de), .pix_hs(pix_hs),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col)
  );

  always #5 clk = ~clk;

  // Pixel memory preloaded with data = address, one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  int fs = 0;
  bit fs_valid = 1'b0;
  int cnt_rd, cnt_de, cnt_win, cnt_done, done_cyc;

  typedef struct packed {
    logic busy, done, rd;
    logic [AW-1:0] addr;
    logic de, hs;
    logic [7:0] pix;
    logic wv;
    logic [9:0] wr, wc;
  } obs_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit issue(input int k, output int line, output int col);
    line = (k >= 0) ? k / P : 0;
    col  = (k >= 0) ? k % P : 0;
    return (k >= 0) && (k < FR) && (col < W);
  endfunction

  // k counts cycles since the first LINE cycle of the accepted frame.
  function automatic obs_t model(input int c);
    obs_t e;
    int k, ln, cl;
    e = '0;
    if (!fs_valid) return e;
    k = c - fs - 1;
    e.busy = (k >= 0) && (k <= FR);
    e.done = (k == FR);
    if (issue(k, ln, cl) && ln < H) begin
      e.rd = 1'b1; e.addr = AW'(ln * W + cl);
    end
    if (issue(k - 1, ln, cl)) begin
      e.de = 1'b1; e.hs = 1'b1;
      if (ln < H) e.pix = 8'(ln * W + cl);
    end
    if (issue(k - 1 - WL, ln, cl) && ln >= 1) begin
      e.wv = 1'b1; e.wr = 10'(ln - 1); e.wc = 10'(cl);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    obs_t a, e;
    e = model(cyc);
    a = '0;
    a.busy = busy; a.done = done; a.rd = mem_rd;
    if (e.rd) a.addr = mem_addr;
    a.de = pix_de; a.hs = pix_hs;
    if (e.de) a.pix = pix_out;
    a.wv = win_valid;
    if (e.wv) begin a.wr = win_row; a.wc = win_col; end
    chk($sformatf("cycle%0d", cyc), 64'(a), 64'(e));
    cnt_rd  += int'(mem_rd);
    cnt_de  += int'(pix_de);
    cnt_win += int'(win_valid);
    if (done) begin cnt_done++; done_cyc = cyc; end
  end

  task automatic note_start();
    if (!fs_valid || (cyc - fs - 1 > FR)) begin
      fs = cyc; fs_valid = 1'b1;
    end
  endtask

  typedef struct {
    int extra;     // cycle of a second start pulse, -1 none
    int rst;       // cycle of a one-cycle reset, -1 none
    int n_done;
    int done_rel;
    int n_rd;
    int n_de;
    int n_win;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int low_run, rises, seen_burst, mism, lows;
    bit ok;
    tbl[0] = '{-1, -1, 1, 25, 12, 16, 12};
    tbl[1] = '{ 5, -1, 1, 25, 12, 16, 12};
    tbl[2] = '{25, -1, 1, 25, 12, 16, 12};
    tbl[3] = '{-1,  9, 0, -1,  6,  5,  0};
    tbl[4] = '{-1,  3, 0, -1,  2,  1,  0};
    tbl[5] = '{-1, -1, 1, 25, 12, 16, 12};

    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      int base;
      @(posedge clk); #1;
      base = cyc;
      cnt_rd = 0; cnt_de = 0; cnt_win = 0; cnt_done = 0; done_cyc = -1;
      for (int r = 0; r < 40; r++) begin
        if (r > 0) begin @(posedge clk); #1; end
        start = (r == 0) || (r == tbl[i].extra);
        reset = (r == tbl[i].rst);
        if (reset) begin
          fs_valid = 1'b0;
          #1;
          chk($sformatf("row%0d_async_rst", i),
              {busy, done, mem_rd, mem_addr, pix_out, pix_de, pix_hs, win_valid, win_row, win_col},
              64'd0);
        end
        if (start) note_start();
      end
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0;
      chk($sformatf("row%0d_done_cnt", i), cnt_done, tbl[i].n_done);
      if (tbl[i].n_done == 1) chk($sformatf("row%0d_done_at", i), done_cyc - base, tbl[i].done_rel);
      chk($sformatf("row%0d_rd_cnt", i), cnt_rd, tbl[i].n_rd);
      chk($sformatf("row%0d_de_cnt", i), cnt_de, tbl[i].n_de);
      chk($sformatf("row%0d_win_cnt", i), cnt_win, tbl[i].n_win);
    end

    // hs gaps between de bursts
    @(posedge clk); #1;
    start = 1'b1; note_start();
    low_run = 0; rises = 0; seen_burst = 0; mism = 0;
    for (int r = 1; r < 35; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pix_de != pix_hs) mism++;
      if (pix_hs) begin
        if (low_run > 0 || seen_burst == 0) rises++;
        if (seen_burst != 0 && low_run > 0) chk("hs_gap", low_run, HB);
        low_run = 0; seen_burst = 1;
      end else if (seen_burst != 0) begin
        low_run++;
      end
    end
    chk("hs_bursts", rises, H + FL);
    chk("de_hs_agree", mism, 0);

    // Back-to-back frames
    @(posedge clk); #1;
    start = 1'b1; note_start();
    ok = 1'b0;
    for (int r = 0; r < 60 && !ok; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ok = done;
    end
    chk("b2b_done1_seen", ok, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; note_start();
    lows = busy ? 0 : 1;
    ok = 1'b0;
    for (int r = 0; r < 60 && !ok; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!busy) lows++;
      ok = done;
    end
    chk("b2b_done2_seen", ok, 1'b1);
    chk("b2b_idle_gap", lows, 1);
    chk("b2b_done2_at", cyc - fs, FR + 1);

    // Random start / reset traffic
    for (int r = 0; r < 800; r++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 149) == 0);
      start = !reset && ($urandom_range(0, 15) == 0);
      if (reset) fs_valid = 1'b0;
      if (start) note_start();
    end
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
